alu_multicycle: RTL and testbench

//  Parametrised successor to the single-cycle ALU: registered ALU with a valid/ready handshake.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_muldiv_iter.sv | 132 +++++++++++++
 rtl/alu_multicycle.sv | 139 +++++++++++++
 tb/tb_alu_multicycle.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encodings and decode helper for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_MUL   = 4'b1010;
  localparam logic [3:0] ALU_MULHU = 4'b1011;
  localparam logic [3:0] ALU_DIVU  = 4'b1100;
  localparam logic [3:0] ALU_REMU  = 4'b1101;
  localparam logic [3:0] ALU_DIV   = 4'b1110;
  localparam logic [3:0] ALU_REM   = 4'b1111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Ops 1010-1111 go through the iterative multiply/divide unit.
  function automatic logic is_iter(input logic [3:0] op);
    return op[3] & (op[2] | op[1]);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider sharing one adder and counter.
// result_o/done_o are combinational and valid during the final iteration cycle.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             kill_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_mul_q, is_mul_d;
  logic             sel_hi_q, sel_hi_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   add_a, add_b;
  logic             add_cin;
  logic [WIDTH+1:0] add_sum;
  logic [WIDTH-1:0] hi_nxt, lo_nxt, raw;
  logic             is_signed, div_ge;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign shifted = {hi_q, lo_q[WIDTH-1]};

  // Multiply accumulates into hi; divide subtracts the divisor from the shifted remainder.
  always_comb begin
    if (is_mul_q) begin
      add_a   = {1'b0, hi_q};
      add_b   = lo_q[0] ? {1'b0, opnd_q} : '0;
      add_cin = 1'b0;
    end else begin
      add_a   = shifted;
      add_b   = ~{1'b0, opnd_q};
      add_cin = 1'b1;
    end
    add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH + 1){1'b0}}, add_cin};
  end

  assign div_ge = add_sum[WIDTH+1];

  always_comb begin
    if (is_mul_q) begin
      hi_nxt = add_sum[WIDTH:1];
      lo_nxt = {add_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_nxt = div_ge ? add_sum[WIDTH-1:0] : shifted[WIDTH-1:0];
      lo_nxt = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  assign raw      = sel_hi_q ? hi_nxt : lo_nxt;
  assign result_o = neg_q ? (~raw + 1'b1) : raw;
  assign done_o   = busy_q & (cnt_q == CntW'(WIDTH - 1));

  assign is_signed = (op_i == ALU_DIV) || (op_i == ALU_REM);
  assign mag_a     = (is_signed & a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
  assign mag_b     = (is_signed & b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    is_mul_d = is_mul_q;
    sel_hi_d = sel_hi_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    if (kill_i) begin
      busy_d = 1'b0;
    end else if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      is_mul_d = (op_i == ALU_MUL) || (op_i == ALU_MULHU);
      sel_hi_d = (op_i == ALU_MULHU) || (op_i == ALU_REMU) || (op_i == ALU_REM);
      neg_d    = (op_i == ALU_DIV) ? (a_i[WIDTH-1] ^ b_i[WIDTH-1]) :
                 (op_i == ALU_REM) ? a_i[WIDTH-1] : 1'b0;
      hi_d     = '0;
      if (is_mul_d) begin
        opnd_d = a_i;
        lo_d   = b_i;
      end else begin
        opnd_d = mag_b;
        lo_d   = mag_a;
      end
    end else if (busy_q) begin
      hi_d  = hi_nxt;
      lo_d  = lo_nxt;
      cnt_d = cnt_q + CntW'(1);
      if (done_o) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      is_mul_q <= 1'b0;
      sel_hi_q <= 1'b0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      is_mul_q <= is_mul_d;
      sel_hi_q <= sel_hi_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with valid/ready handshake: single-cycle fast ops plus iterative mul/div.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  SrcA,
  input  logic [WIDTH-1:0]  SrcB,
  input  logic [CTRL_W-1:0] ALUcontrol,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  ALUResult,
  output logic              zero,
  output logic              busy
);

  localparam int unsigned ShW = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic [3:0]       op;
  logic [ShW-1:0]   shamt;
  logic [WIDTH-1:0] fast_res, special_res, iter_res, min_val;
  logic             iter_start, iter_done;
  logic             is_div, is_quot, div_zero, div_ovf, special;

  assign op      = ALUcontrol[3:0];
  assign shamt   = SrcB[ShW-1:0];
  assign min_val = {1'b1, {(WIDTH - 1){1'b0}}};

  always_comb begin
    fast_res = '0;
    case (op)
      ALU_ADD:  fast_res = SrcA + SrcB;
      ALU_SUB:  fast_res = SrcA - SrcB;
      ALU_AND:  fast_res = SrcA & SrcB;
      ALU_OR:   fast_res = SrcA | SrcB;
      ALU_XOR:  fast_res = SrcA ^ SrcB;
      ALU_SLT:  fast_res = {{(WIDTH - 1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      ALU_SLTU: fast_res = {{(WIDTH - 1){1'b0}}, SrcA < SrcB};
      ALU_SLL:  fast_res = SrcA << shamt;
      ALU_SRL:  fast_res = SrcA >> shamt;
      ALU_SRA:  fast_res = $unsigned($signed(SrcA) >>> shamt);
      default:  fast_res = '0;
    endcase
  end

  // Divide-by-zero and signed overflow bypass the iterative unit entirely.
  assign is_div   = (op == ALU_DIVU) || (op == ALU_REMU) || (op == ALU_DIV) || (op == ALU_REM);
  assign is_quot  = (op == ALU_DIVU) || (op == ALU_DIV);
  assign div_zero = (SrcB == '0);
  assign div_ovf  = ((op == ALU_DIV) || (op == ALU_REM)) && (SrcA == min_val) && (&SrcB);
  assign special  = is_div & (div_zero | div_ovf);

  always_comb begin
    if (div_zero) begin
      special_res = is_quot ? '1 : SrcA;
    end else begin
      special_res = is_quot ? min_val : '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    iter_start = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (is_iter(op) && !special) begin
              state_d    = ST_CALC;
              iter_start = 1'b1;
            end else begin
              state_d  = ST_DONE;
              result_d = is_iter(op) ? special_res : fast_res;
            end
          end
        end
        ST_CALC: begin
          if (iter_done) begin
            state_d  = ST_DONE;
            result_d = iter_res;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (iter_start),
    .kill_i   (flush),
    .op_i     (op),
    .a_i      (SrcA),
    .b_i      (SrcB),
    .done_o   (iter_done),
    .result_o (iter_res)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign ALUResult = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed scoreboard bench: stimulus pushes expected results, a monitor pops on handshake.
module tb_alu_multicycle;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  ALUcontrol;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        zero;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  alu_multicycle #(
    .WIDTH  (32),
    .CTRL_W (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUcontrol (ALUcontrol),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .zero       (zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("result", ALUResult, e);
        check("zero", {31'd0, zero}, {31'd0, e == 32'd0});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input int hold);
    int   cyc;
    logic rdy_seen;
    wait_ready();
    in_valid   = 1'b1;
    ALUcontrol = op;
    SrcA       = a;
    SrcB       = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back(exp);
    cyc      = 1;
    rdy_seen = 1'b0;
    while (!out_valid && cyc < lat + 4) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("out_valid", {31'd0, out_valid}, 32'd1);
    check("latency", cyc, lat);
    if (lat > 1) check("in_ready_busy", {31'd0, rdy_seen}, 32'd0);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk);
        #1;
      end
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_result", ALUResult, exp);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_after", {31'd0, in_ready}, 32'd1);
  endtask

  // Starts a DIVU, runs 10 iterations, then kills it with flush or reset.
  task automatic abort_divu(input logic use_reset, input logic [31:0] prev);
    logic seen;
    wait_ready();
    in_valid   = 1'b1;
    ALUcontrol = 4'b1100;
    SrcA       = 32'd1000;
    SrcB       = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    if (use_reset) begin
      rst_n = 1'b0;
      #2;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", ALUResult, 32'd0);
      check("rst_zero", {31'd0, zero}, 32'd1);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
    end else begin
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_busy", {31'd0, busy}, 32'd0);
      check("flush_out_valid", {31'd0, out_valid}, 32'd0);
      check("flush_result", ALUResult, prev);
    end
    out_ready = 1'b1;
    seen      = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    check("abort_no_output", {31'd0, seen}, 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    SrcA       = '0;
    SrcB       = '0;
    ALUcontrol = '0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    #12;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", ALUResult, 32'd0);
    check("reset_zero", {31'd0, zero}, 32'd1);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_vec(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 3);
    run_vec(4'b0001, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1, 0);
    run_vec(4'b0010, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1, 0);
    run_vec(4'b0011, 32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 1, 0);
    run_vec(4'b0100, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA, 1, 0);
    run_vec(4'b1001, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1, 0);
    run_vec(4'b1000, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1, 0);
    run_vec(4'b0111, 32'h0000_0001, 32'h0000_0023, 32'h0000_0008, 1, 0);
    run_vec(4'b0110, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1, 0);
    run_vec(4'b0101, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
    run_vec(4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, 0);
    run_vec(4'b1010, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33, 0);
    run_vec(4'b1011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33, 2);
    run_vec(4'b1010, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 33, 0);
    run_vec(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_vec(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 0);
    run_vec(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_vec(4'b1111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
    run_vec(4'b1100, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1, 0);
    run_vec(4'b1101, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1, 0);
    run_vec(4'b1110, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, 1, 0);
    run_vec(4'b1111, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 1, 0);
    run_vec(4'b1110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, 0);
    run_vec(4'b1111, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, 0);
    run_vec(4'b1100, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33, 0);
    run_vec(4'b1101, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33, 1);

    abort_divu(1'b0, 32'h0000_0002);
    abort_divu(1'b1, 32'h0000_0000);

    run_vec(4'b0000, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
